// File: rtl/tpu_pkg.sv
// ============================================================================
//  Module   : tpu_pkg
//  Purpose  : Pin map, element width and host FSM states for the TPU pin protocol.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package tpu_pkg;

   localparam int ELEM_W         = 8;

   // uio_in / uio_out bit positions, shared by host driver and TPU controller
   localparam int LOAD_EN_BIT    = 0;
   localparam int SEL_AB_BIT     = 1;
   localparam int INDEX_LSB      = 2;
   localparam int OUTPUT_EN_BIT  = 4;
   localparam int OUTPUT_SEL_LSB = 5;
   localparam int DONE_BIT       = 7;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_WAIT = 3'd2,
      ST_READ = 3'd3,
      ST_RESP = 3'd4
   } host_state_e;

endpackage

`default_nettype wire

// File: rtl/tpu_host_watchdog.sv
// ============================================================================
//  Module   : tpu_host_watchdog
//  Purpose  : Counts cycles while run_i is high; flags expiry on the last allowed cycle.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tpu_host_watchdog #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic run_i,
   output logic expired_o
);

   localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // expired_o is high during the TIMEOUT_CYCLES-th consecutive run cycle
   assign expired_o = run_i && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      count_d = count_q;
      if (!run_i) begin
         count_d = '0;
      end else if (!expired_o) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/tpu_host_driver.sv
// ============================================================================
//  Module   : tpu_host_driver
//  Purpose  : Host master serialising a 2x2 int8 job onto TPU pins and reading C back.
//             Optional WAIT timeout enabled by the TPU_HOST_TIMEOUT_EN macro.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tpu_host_driver
   import tpu_pkg::*;
#(
   parameter int READ_LATENCY   = 1,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                job_valid,
   output logic                job_ready,
   input  logic [4*ELEM_W-1:0] job_a,
   input  logic [4*ELEM_W-1:0] job_b,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [4*ELEM_W-1:0] res_data,
   output logic                res_err,
   output logic [7:0]          tpu_ui_out,
   output logic [7:0]          tpu_uio_out,
   input  logic [7:0]          tpu_uo_in,
   input  logic                tpu_done_in
);

   localparam int RL_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

   host_state_e         state_q, state_d;
   logic [2:0]          step_q, step_d;
   logic [RL_W-1:0]     lat_q, lat_d;
   logic [4*ELEM_W-1:0] a_q, a_d, b_q, b_d;
   logic [4*ELEM_W-1:0] res_data_q, res_data_d;
   logic                res_err_q, res_err_d;
   logic                res_valid_q, res_valid_d;
   logic [7:0]          ui_q, ui_d, uio_q, uio_d;
   logic                wd_expired;

`ifdef TPU_HOST_TIMEOUT_EN
   tpu_host_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .run_i     (state_q == ST_WAIT),
      .expired_o (wd_expired)
   );
`else
   // No timeout: the parameter is kept only so both builds share one interface
   assign wd_expired = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      lat_d      = lat_q;
      a_d        = a_q;
      b_d        = b_q;
      res_data_d = res_data_q;
      res_err_d  = res_err_q;
      case (state_q)
         ST_IDLE: begin
            if (job_valid) begin
               state_d    = ST_LOAD;
               step_d     = 3'd0;
               a_d        = job_a;
               b_d        = job_b;
               res_data_d = '0;
               res_err_d  = 1'b0;
            end
         end
         ST_LOAD: begin
            if (step_q == 3'd7) begin
               state_d = ST_WAIT;
               step_d  = 3'd0;
            end else begin
               step_d = step_q + 3'd1;
            end
         end
         ST_WAIT: begin
            if (tpu_done_in) begin
               state_d = ST_READ;
               step_d  = 3'd0;
               lat_d   = '0;
            end else if (wd_expired) begin
               state_d    = ST_RESP;
               res_err_d  = 1'b1;
               res_data_d = '0;
            end
         end
         ST_READ: begin
            if (lat_q == RL_W'(READ_LATENCY)) begin
               res_data_d[ELEM_W*int'(step_q[1:0]) +: ELEM_W] = tpu_uo_in;
               lat_d = '0;
               if (step_q[1:0] == 2'd3) begin
                  state_d = ST_RESP;
               end else begin
                  step_d = step_q + 3'd1;
               end
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         ST_RESP: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Pins are a function of the next state so they are registered with it
      ui_d  = '0;
      uio_d = '0;
      case (state_d)
         ST_LOAD: begin
            uio_d[LOAD_EN_BIT]        = 1'b1;
            uio_d[SEL_AB_BIT]         = step_d[2];
            uio_d[INDEX_LSB +: 2]     = step_d[1:0];
            ui_d = step_d[2] ? b_d[ELEM_W*int'(step_d[1:0]) +: ELEM_W]
                             : a_d[ELEM_W*int'(step_d[1:0]) +: ELEM_W];
         end
         ST_READ: begin
            uio_d[OUTPUT_EN_BIT]      = 1'b1;
            uio_d[OUTPUT_SEL_LSB +: 2] = step_d[1:0];
         end
         default: ;
      endcase
      res_valid_d = (state_d == ST_RESP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         step_q      <= '0;
         lat_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         res_data_q  <= '0;
         res_err_q   <= 1'b0;
         res_valid_q <= 1'b0;
         ui_q        <= '0;
         uio_q       <= '0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         lat_q       <= lat_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_data_q  <= res_data_d;
         res_err_q   <= res_err_d;
         res_valid_q <= res_valid_d;
         ui_q        <= ui_d;
         uio_q       <= uio_d;
      end
   end

   assign job_ready   = (state_q == ST_IDLE);
   assign res_valid   = res_valid_q;
   assign res_data    = res_data_q;
   assign res_err     = res_err_q;
   assign tpu_ui_out  = ui_q;
   assign tpu_uio_out = uio_q;

endmodule

`default_nettype wire

// File: tb/tb_tpu_host_driver.sv
// ============================================================================
//  Module   : tb_tpu_host_driver
//  Purpose  : Self-checking bench for tpu_host_driver with a behavioural TPU model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tpu_host_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        job_valid = 1'b0;
   logic        job_ready;
   logic [31:0] job_a = '0;
   logic [31:0] job_b = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res_data;
   logic        res_err;
   logic [7:0]  tpu_ui_out;
   logic [7:0]  tpu_uio_out;
   logic [7:0]  tpu_uo_in = '0;
   logic        tpu_done_in = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   tpu_host_driver #(
      .READ_LATENCY   (1),
      .TIMEOUT_CYCLES (10)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .job_valid   (job_valid),
      .job_ready   (job_ready),
      .job_a       (job_a),
      .job_b       (job_b),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_err     (res_err),
      .tpu_ui_out  (tpu_ui_out),
      .tpu_uio_out (tpu_uio_out),
      .tpu_uo_in   (tpu_uo_in),
      .tpu_done_in (tpu_done_in)
   );

   // Row-major 2x2 product, each C element truncated to 8 bits
   function automatic logic [31:0] matmul(input logic [31:0] a, input logic [31:0] b);
      int av[4];
      int bv[4];
      int cv[4];
      logic [31:0] r;
      for (int i = 0; i < 4; i++) begin
         av[i] = int'(a[8*i +: 8]);
         bv[i] = int'(b[8*i +: 8]);
      end
      cv[0] = av[0]*bv[0] + av[1]*bv[2];
      cv[1] = av[0]*bv[1] + av[1]*bv[3];
      cv[2] = av[2]*bv[0] + av[3]*bv[2];
      cv[3] = av[2]*bv[1] + av[3]*bv[3];
      for (int i = 0; i < 4; i++) r[8*i +: 8] = cv[i][7:0];
      return r;
   endfunction

   // TPU model: captures loaded operands, answers output_sel one cycle later
   logic [31:0] tpu_a = '0;
   logic [31:0] tpu_b = '0;
   always @(posedge clk) begin
      logic [31:0] c;
      if (tpu_uio_out[0]) begin
         if (tpu_uio_out[1]) tpu_b[8*tpu_uio_out[3:2] +: 8] <= tpu_ui_out;
         else                tpu_a[8*tpu_uio_out[3:2] +: 8] <= tpu_ui_out;
      end
      c = matmul(tpu_a, tpu_b);
      tpu_uo_in <= tpu_uio_out[4] ? c[8*tpu_uio_out[6:5] +: 8] : 8'h00;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic offer(input logic [31:0] a, input logic [31:0] b);
      job_valid = 1'b1;
      job_a     = a;
      job_b     = b;
      tick();
      job_valid = 1'b0;
   endtask

   task automatic wait_res(output int n);
      n = 0;
      while (!res_valid && n < 200) begin
         tick();
         n++;
      end
   endtask

   // Full job with done raised dly cycles into WAIT; lat is accept-relative cycle of res_valid
   task automatic run_job(input logic [31:0] a, input logic [31:0] b, input int dly,
                          output int lat, output logic [31:0] d, output logic e);
      int n;
      offer(a, b);
      repeat (8) tick();
      repeat (dly) tick();
      tpu_done_in = 1'b1;
      tick();
      tpu_done_in = 1'b0;
      wait_res(n);
      lat = (n < 200) ? 10 + dly + n : -1;
      d   = res_data;
      e   = res_err;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      n_checks += 6;
      if (job_ready !== 1'b1) begin n_fail++; $display("FAIL reset_job_ready: got %b expected 1", job_ready); end
      if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
      if (res_data !== 32'h0) begin n_fail++; $display("FAIL reset_res_data: got %h expected 0", res_data); end
      if (res_err !== 1'b0) begin n_fail++; $display("FAIL reset_res_err: got %b expected 0", res_err); end
      if (tpu_ui_out !== 8'h0) begin n_fail++; $display("FAIL reset_ui: got %h expected 00", tpu_ui_out); end
      if (tpu_uio_out !== 8'h0) begin n_fail++; $display("FAIL reset_uio: got %h expected 00", tpu_uio_out); end
   endtask

   task automatic test_basic();
      logic [31:0] a = 32'h04030201;
      logic [31:0] b = 32'h08070605;
      logic [7:0]  eu, ed;
      n_checks++;
      if (job_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b expected 1", job_ready); end
      offer(a, b);
      for (int k = 0; k < 8; k++) begin
         eu = 8'(1 | ((k >> 2) << 1) | ((k & 3) << 2));
         ed = (k < 4) ? a[8*k +: 8] : b[8*(k-4) +: 8];
         n_checks += 2;
         if (tpu_uio_out !== eu) begin n_fail++; $display("FAIL basic_load_uio k=%0d: got %h expected %h", k, tpu_uio_out, eu); end
         if (tpu_ui_out !== ed) begin n_fail++; $display("FAIL basic_load_ui k=%0d: got %h expected %h", k, tpu_ui_out, ed); end
         tick();
      end
      n_checks += 2;
      if (tpu_uio_out !== 8'h0) begin n_fail++; $display("FAIL basic_wait_uio: got %h expected 00", tpu_uio_out); end
      if (job_ready !== 1'b0) begin n_fail++; $display("FAIL basic_busy_ready: got %b expected 0", job_ready); end
      repeat (3) tick();
      tpu_done_in = 1'b1;
      tick();
      tpu_done_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         for (int r = 0; r < 2; r++) begin
            eu = 8'(8'h10 | (i << 5));
            n_checks++;
            if (tpu_uio_out !== eu) begin n_fail++; $display("FAIL basic_read_uio i=%0d: got %h expected %h", i, tpu_uio_out, eu); end
            tick();
         end
      end
      n_checks += 3;
      if (res_valid !== 1'b1) begin n_fail++; $display("FAIL basic_res_valid: got %b expected 1", res_valid); end
      if (res_data !== 32'h322B1613) begin n_fail++; $display("FAIL basic_res_data: got %h expected 322b1613", res_data); end
      if (res_err !== 1'b0) begin n_fail++; $display("FAIL basic_res_err: got %b expected 0", res_err); end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      n_checks += 2;
      if (res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_res_drop: got %b expected 0", res_valid); end
      if (job_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_back: got %b expected 1", job_ready); end
   endtask

   task automatic test_random();
      logic [31:0] a, b, d;
      logic        e;
      int          dly, lat;
      for (int j = 0; j < 6; j++) begin
         a   = $urandom;
         b   = $urandom;
         dly = int'($urandom_range(0, 5));
         run_job(a, b, dly, lat, d, e);
         n_checks += 3;
         if (lat != 18 + dly) begin n_fail++; $display("FAIL random_latency j=%0d: got %0d expected %0d", j, lat, 18 + dly); end
         if (d !== matmul(a, b)) begin n_fail++; $display("FAIL random_data j=%0d: got %h expected %h", j, d, matmul(a, b)); end
         if (e !== 1'b0) begin n_fail++; $display("FAIL random_err j=%0d: got %b expected 0", j, e); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] a = $urandom;
      logic [31:0] b = $urandom;
      int n;
      offer(a, b);
      repeat (8) tick();
      tpu_done_in = 1'b1;
      tick();
      tpu_done_in = 1'b0;
      wait_res(n);
      n_checks++;
      if (10 + n != 18) begin n_fail++; $display("FAIL bp_min_latency: got %0d expected 18", 10 + n); end
      for (int c = 0; c < 5; c++) begin
         n_checks += 3;
         if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid c=%0d: got %b expected 1", c, res_valid); end
         if (res_data !== matmul(a, b)) begin n_fail++; $display("FAIL bp_data c=%0d: got %h expected %h", c, res_data, matmul(a, b)); end
         if (job_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready c=%0d: got %b expected 0", c, job_ready); end
         tick();
      end
      res_ready = 1'b1;
      n_checks++;
      if (job_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_hs: got %b expected 0", job_ready); end
      tick();
      res_ready = 1'b0;
      n_checks += 2;
      if (job_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after: got %b expected 1", job_ready); end
      if (res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_after: got %b expected 0", res_valid); end
   endtask

   task automatic test_stale_done();
      logic [31:0] a = $urandom;
      logic [31:0] b = $urandom;
      int n;
      tpu_done_in = 1'b1;
      offer(a, b);
      repeat (8) tick();
      tpu_done_in = 1'b0;
      repeat (5) tick();
      n_checks++;
      if (tpu_uio_out !== 8'h0) begin n_fail++; $display("FAIL stale_c14_uio: got %h expected 00", tpu_uio_out); end
      tick();
      tpu_done_in = 1'b1;
      n_checks++;
      if (tpu_uio_out !== 8'h0) begin n_fail++; $display("FAIL stale_c15_uio: got %h expected 00", tpu_uio_out); end
      tick();
      tpu_done_in = 1'b0;
      n_checks++;
      if (tpu_uio_out !== 8'h10) begin n_fail++; $display("FAIL stale_c16_uio: got %h expected 10", tpu_uio_out); end
      wait_res(n);
      n_checks++;
      if (res_data !== matmul(a, b) || n >= 200) begin n_fail++; $display("FAIL stale_data: got %h expected %h", res_data, matmul(a, b)); end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_reset_mid_job();
      logic [31:0] a, b, d;
      logic        e;
      int          lat;
      offer($urandom, $urandom);
      repeat (3) tick();
      n_checks++;
      if (tpu_uio_out !== 8'h0D) begin n_fail++; $display("FAIL rstmid_load3: got %h expected 0d", tpu_uio_out); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks += 4;
      if (tpu_uio_out !== 8'h0) begin n_fail++; $display("FAIL rstmid_uio: got %h expected 00", tpu_uio_out); end
      if (tpu_ui_out !== 8'h0) begin n_fail++; $display("FAIL rstmid_ui: got %h expected 00", tpu_ui_out); end
      if (job_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 1", job_ready); end
      if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", res_valid); end
      a = $urandom;
      b = $urandom;
      run_job(a, b, 2, lat, d, e);
      n_checks += 2;
      if (lat != 20) begin n_fail++; $display("FAIL rstmid_latency: got %0d expected 20", lat); end
      if (d !== matmul(a, b)) begin n_fail++; $display("FAIL rstmid_data: got %h expected %h", d, matmul(a, b)); end
   endtask

   task automatic test_timeout();
      logic [31:0] a = $urandom;
      logic [31:0] b = $urandom;
      int n;
      offer(a, b);
      repeat (8) tick();
`ifdef TPU_HOST_TIMEOUT_EN
      wait_res(n);
      n_checks += 3;
      if (9 + n != 19) begin n_fail++; $display("FAIL timeout_latency: got %0d expected 19", 9 + n); end
      if (res_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b expected 1", res_err); end
      if (res_data !== 32'h0) begin n_fail++; $display("FAIL timeout_data: got %h expected 0", res_data); end
`else
      n = 0;
      repeat (1000) begin
         if (res_valid || job_ready || tpu_uio_out != 8'h0) n++;
         tick();
      end
      n_checks++;
      if (n != 0) begin n_fail++; $display("FAIL wait_forever: got %0d non-wait cycles expected 0", n); end
      tpu_done_in = 1'b1;
      tick();
      tpu_done_in = 1'b0;
      wait_res(n);
      n_checks += 2;
      if (res_data !== matmul(a, b) || n >= 200) begin n_fail++; $display("FAIL late_done_data: got %h expected %h", res_data, matmul(a, b)); end
      if (res_err !== 1'b0) begin n_fail++; $display("FAIL late_done_err: got %b expected 0", res_err); end
`endif
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_busy_ignore();
      logic [31:0] a1 = $urandom;
      logic [31:0] b1 = $urandom;
      logic [31:0] a2 = ~a1;
      logic [31:0] b2 = b1 ^ 32'h5A5A5A5A;
      int n;
      offer(a1, b1);
      repeat (8) tick();
      tpu_done_in = 1'b1;
      tick();
      tpu_done_in = 1'b0;
      tick();
      job_valid = 1'b1;
      job_a     = a2;
      job_b     = b2;
      tick();
      job_valid = 1'b0;
      wait_res(n);
      n_checks++;
      if (res_data !== matmul(a1, b1) || n >= 200) begin n_fail++; $display("FAIL busy_data: got %h expected %h", res_data, matmul(a1, b1)); end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      n = 0;
      repeat (4) begin
         if (tpu_uio_out != 8'h0 || !job_ready) n++;
         tick();
      end
      n_checks++;
      if (n != 0) begin n_fail++; $display("FAIL busy_no_second_job: got %0d active cycles expected 0", n); end
   endtask

   initial begin
      tick();
      test_reset();
      test_basic();
      test_random();
      test_backpressure();
      test_stale_done();
      test_reset_mid_job();
      test_timeout();
      test_busy_ignore();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/tpu_host_driver.md
# tpu_host_driver

Host-side master for the TPU pin protocol. It accepts one 2x2 int8 matrix-multiply job (A and B, four bytes each) over a valid/ready port and serialises the operands onto the TPU's `ui_in`/`uio_in` load pins. It then waits for `done` on `uio_out[7]`, reads C[0..3] back through the output-select pins, and returns them as one result beat. It sits on the FPGA/test-harness side and drives the TPU pins directly in the same clock domain.

## Interface
- `READ_LATENCY`, default 1: cycles between driving `output_sel` and sampling `tpu_uo_in`.
- `TIMEOUT_CYCLES`, default 255: maximum WAIT cycles before error. Used only with `TPU_HOST_TIMEOUT_EN`.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `job_valid` in 1: job offered.
- `job_ready` out 1: high only in IDLE.
- `job_a` in 32: {A3,A2,A1,A0}, one byte per element.
- `job_b` in 32: {B3,B2,B1,B0}.
- `res_valid` out 1: result beat valid.
- `res_ready` in 1: result accepted.
- `res_data` out 32: {C3,C2,C1,C0}.
- `res_err` out 1: job ended by timeout. Qualified by `res_valid`.
- `tpu_ui_out` out 8: drives TPU `ui_in` (load data).
- `tpu_uio_out` out 8: drives TPU `uio_in`. Bit 0 load_en, bit 1 sel_ab (0=A, 1=B), bits 3:2 load index, bit 4 output_en, bits 6:5 output_sel, bit 7 always 0.
- `tpu_uo_in` in 8: TPU `uo_out` (C element data).
- `tpu_done_in` in 1: TPU `uio_out[7]`.

## Operation
- States:
  - IDLE: `job_ready`=1. On `job_valid`&&`job_ready`, latch `job_a`/`job_b` and go to LOAD.
  - LOAD: 8 cycles, k=0..7. Drive load_en=1, sel_ab=k[2], index=k[1:0], `tpu_ui_out`=A[k] for k<4 and B[k-4] for k≥4. Then go to WAIT.
  - WAIT: all pin outputs 0. Go to READ on the first cycle `tpu_done_in`=1. Done sampled during LOAD or in the LOAD→WAIT transition cycle is ignored (stale done from the previous job).
  - READ: for i=0..3, drive output_en=1 and output_sel=i for READ_LATENCY+1 cycles. Capture `tpu_uo_in` into C[i] on the last of those cycles. Then go to RESP.
  - RESP: `res_valid`=1, with `res_data`/`res_err` stable. On `res_ready`, go to IDLE.
- `job_valid` outside IDLE is ignored; no queueing.
- All pin outputs and `res_*` are registered, with no combinational path from inputs.
- Data is unsigned pass-through: no arithmetic, no width conversion.

## Timing
- Reset values: `job_ready`=1 (state IDLE), `res_valid`=0, `res_data`=0, `res_err`=0, `tpu_ui_out`=0, `tpu_uio_out`=0.
- Reset mid-job (any state) abandons the job. Pins go to 0 the cycle after `rst` is sampled. Latched operands and results are cleared.
- Timeline, with acceptance at cycle 0:
  - Load pins active cycles 1–8.
  - WAIT starts at cycle 9.
  - If done is first seen at cycle d≥9, READ occupies d+1 .. d+4·(READ_LATENCY+1).
  - `res_valid` rises on the next cycle.
- Minimum job-to-result latency with READ_LATENCY=1 and done at cycle 9: 18 cycles.
- RESP→IDLE takes one cycle. `job_ready` returns the cycle after the result handshake, so there is no same-cycle re-accept.

## Configuration
- `TPU_HOST_TIMEOUT_EN` defined:
  - A WAIT counter starts at 0 on entry.
  - If it reaches TIMEOUT_CYCLES without done, go to RESP with `res_err`=1 and `res_data`=0.
  - Done and timeout in the same cycle: done wins.
- Not defined: no counter; WAIT waits indefinitely; `res_err` is tied 0.

## Structure
- Shared package `tpu_pkg` holds:
  - the pin bit-position constants (LOAD_EN_BIT, SEL_AB_BIT, INDEX_LSB, OUTPUT_EN_BIT, OUTPUT_SEL_LSB, DONE_BIT);
  - ELEM_W=8;
  - the state enum.
- The TPU controller uses the same constants, so both ends agree on the pin map.
- One sub-module, `tpu_host_watchdog` (counter plus expiry flag), instantiated only under `TPU_HOST_TIMEOUT_EN`.

## Test plan
- Basic job with A=[1,2,3,4], B=[5,6,7,8], and a TPU model raising done 3 cycles into WAIT with C=[19,22,43,50].
  - Pin trace shows 8 load cycles with correct sel_ab/index/data, then 4 read selects.
  - `res_data`=0x322B1613, `res_err`=0.
- Backpressure: hold `res_ready`=0 for 5 cycles. `res_valid` and `res_data` stay stable; `job_ready` stays 0 until one cycle after the handshake.
- Stale done: `tpu_done_in` held 1 throughout LOAD and the first WAIT cycle, then 0, then 1 at cycle 15. READ starts at cycle 16, not earlier.
- Reset at LOAD element 3. All pins read 0 the next cycle, `job_ready`=1, `res_valid`=0. A fresh job then completes correctly.
- Timeout (macro on, TIMEOUT_CYCLES=10, done never asserted): `res_valid` with `res_err`=1 and `res_data`=0 appears 10 cycles into WAIT. With the macro off, the driver stays in WAIT for 1000 cycles.
- Busy ignore: `job_valid` pulsed during READ with different operands. The result matches the first job only, and no second job starts.
